// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, parity selectors and bit-period helper for uart_tx_frame.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int calc_bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead synchronous FIFO with full/empty/level, async active-low reset.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   level_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_out  = level_q == (AW+1)'(DEPTH);
    assign empty_out = level_q == '0;
    assign do_push   = push_in && !full_out;
    assign do_pop    = pop_in && !empty_out;
    assign data_out  = mem_q[rd_q];
    assign level_out = level_q;

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= data_in;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (data width, parity, stop bits) with valid/ready input.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the line FSM.
module uart_tx_frame #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_MODE      = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          busy_out,
    output logic                          tx_wire_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

    import uart_pkg::*;

    localparam int BIT_PERIOD = calc_bit_period(INPUT_CLOCK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(BIT_PERIOD);
    localparam int IW = $clog2(DATA_BITS);

    if (BIT_PERIOD < 2) begin : g_bad_period
        $error("uart_tx_frame: BIT_PERIOD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [IW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   bit_end, frame_end, fsm_ready, load, src_valid;
    logic [DATA_BITS-1:0]   src_data;

    assign bit_end   = baud_q == BW'(BIT_PERIOD - 1);
    assign frame_end = state_q == STOP && bit_end && bit_q == IW'(STOP_BITS - 1);
    assign fsm_ready = state_q == IDLE || frame_end;
    assign load      = src_valid && fsm_ready;

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push_in   (valid_in && !fifo_full),
        .data_in   (data_in),
        .pop_in    (load),
        .data_out  (src_data),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .level_out (fifo_level_out)
    );

    assign src_valid = !fifo_empty;
    assign ready_out = !fifo_full;
    assign busy_out  = !fifo_empty || state_q != IDLE;
`else
    assign src_valid      = valid_in;
    assign src_data       = data_in;
    assign ready_out      = fsm_ready;
    assign busy_out       = state_q != IDLE;
    assign fifo_level_out = '0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // bit_q indexes payload bits in DATA and counts stop bits in STOP.
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            IDLE:   baud_d = '0;
            START:  if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                if (bit_q == IW'(DATA_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = PARITY_MODE != PARITY_NONE ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: if (bit_end) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == IW'(STOP_BITS - 1)) begin
                    bit_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = src_data;
            par_d   = (^src_data) ^ (PARITY_MODE == PARITY_ODD);
        end
    end

    always_comb begin
        tx_wire_out = state_q == START  ? 1'b0 :
                      state_q == DATA   ? shift_q[0] :
                      state_q == PARITY ? par_q : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized and directed checks of uart_tx_frame against a bit-list line model.
module tb_uart_tx_frame;

    localparam int BP = 10;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [8:0] din [4];
    logic       vin [4];
    logic       rdy [4];
    logic       busy [4];
    logic       tx [4];
    logic [4:0] lvl [3];
    logic [2:0] lvl_f;

    int checks = 0;
    int failures = 0;
    int db [4] = '{8, 7, 8, 8};
    int pm [4] = '{0, 1, 2, 0};
    int sb [4] = '{1, 2, 1, 1};
    bit exp_bits [$];

    uart_tx_frame #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(din[0][7:0]), .valid_in(vin[0]),
        .ready_out(rdy[0]), .busy_out(busy[0]), .tx_wire_out(tx[0]), .fifo_level_out(lvl[0]));
    uart_tx_frame #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                    .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(din[1][6:0]), .valid_in(vin[1]),
        .ready_out(rdy[1]), .busy_out(busy[1]), .tx_wire_out(tx[1]), .fifo_level_out(lvl[1]));
    uart_tx_frame #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_MODE(2)) dut_c (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(din[2][7:0]), .valid_in(vin[2]),
        .ready_out(rdy[2]), .busy_out(busy[2]), .tx_wire_out(tx[2]), .fifo_level_out(lvl[2]));
    uart_tx_frame #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut_f (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(din[3][7:0]), .valid_in(vin[3]),
        .ready_out(rdy[3]), .busy_out(busy[3]), .tx_wire_out(tx[3]), .fifo_level_out(lvl_f));

    // Line model: start 0, payload LSB first, optional parity, stop 1s.
    function automatic void add_frame(int k, logic [8:0] d);
        int ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < db[k]; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm[k] != 0) exp_bits.push_back((ones % 2 == 1) ^ (pm[k] == 2));
        for (int i = 0; i < sb[k]; i++) exp_bits.push_back(1'b1);
    endfunction

    task automatic drive(int k, logic [8:0] q [$]);
        foreach (q[i]) begin
            int t = 0;
            din[k] = q[i];
            vin[k] = 1'b1;
            @(negedge clk_in);
            while (!rdy[k] && t < 500) begin
                @(negedge clk_in);
                t++;
            end
            if (t >= 500) begin
                checks++;
                failures++;
                $display("FAIL drive_timeout k=%0d item=%0d ready_out stayed 0, required 1", k, i);
            end
            @(posedge clk_in);
            #1;
        end
        vin[k] = 1'b0;
    endtask

    task automatic check_stream(int k, logic [8:0] q [$], string nm);
        int fl, n, t = 0, bad_tx = -1, bad_busy = -1, bad_rdy = -1;
        logic got_tx = 1'b0, got_rdy = 1'b0;
        exp_bits.delete();
        foreach (q[i]) add_frame(k, q[i]);
        fl = exp_bits.size() / q.size() * BP;
        n = exp_bits.size() * BP;
        @(negedge clk_in);
        while (!(vin[k] && rdy[k]) && t < 500) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 500) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout k=%0d no accept seen", nm, k);
        end
        @(posedge clk_in);
        #1;
        repeat (LAT - 1) @(posedge clk_in);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_in);
            if (tx[k] !== exp_bits[c / BP] && bad_tx < 0) begin
                bad_tx = c;
                got_tx = tx[k];
            end
            if (busy[k] !== 1'b1 && bad_busy < 0) bad_busy = c;
`ifndef UART_TX_FIFO_EN
            if (rdy[k] !== (c % fl == fl - 1) && bad_rdy < 0) begin
                bad_rdy = c;
                got_rdy = rdy[k];
            end
`endif
        end
        checks++;
        if (bad_tx >= 0) begin
            failures++;
            $display("FAIL %s_tx k=%0d cycle %0d got %b required %b", nm, k, bad_tx, got_tx, exp_bits[bad_tx / BP]);
        end
        checks++;
        if (bad_busy >= 0) begin
            failures++;
            $display("FAIL %s_busy k=%0d cycle %0d got 0 required 1", nm, k, bad_busy);
        end
`ifndef UART_TX_FIFO_EN
        checks++;
        if (bad_rdy >= 0) begin
            failures++;
            $display("FAIL %s_ready k=%0d cycle %0d got %b required %b", nm, k, bad_rdy, got_rdy, ~got_rdy);
        end
`endif
        @(negedge clk_in);
        checks++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle k=%0d tx=%b busy=%b required tx=1 busy=0", nm, k, tx[k], busy[k]);
        end
    endtask

    task automatic run_stream(int k, logic [8:0] q [$], string nm);
        @(posedge clk_in);
        #1;
        fork
            drive(k, q);
            check_stream(k, q, nm);
        join
    endtask

    task automatic test_reset;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0;
            din[k] = '0;
        end
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold k=%0d tx=%b busy=%b required tx=1 busy=0", k, tx[k], busy[k]);
            end
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b1 || lvl[k] !== 5'd0 || tx[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_release k=%0d ready=%b level=%0d tx=%b required 1/0/1", k, rdy[k], lvl[k], tx[k]);
            end
        end
    endtask

    task automatic test_directed;
        logic [8:0] q [$];
        q.delete(); q.push_back(9'h0A5);
        run_stream(0, q, "8n1_a5");
        q.delete(); q.push_back(9'h055);
        run_stream(1, q, "7e2_55");
        q.delete(); q.push_back(9'h001);
        run_stream(2, q, "odd_01");
        q.delete(); q.push_back(9'h000);
        run_stream(2, q, "odd_00");
    endtask

    task automatic test_back_to_back;
        logic [8:0] q [$];
        q.push_back(9'h012);
        q.push_back(9'h034);
        run_stream(0, q, "b2b");
    endtask

    task automatic test_random;
        logic [8:0] q [$];
        for (int k = 0; k < 3; k++) begin
            q.delete();
            for (int i = 0; i < 3; i++) q.push_back(9'($urandom_range(0, 511)));
            run_stream(k, q, "rand");
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] d = 9'($urandom_range(0, 255));
        logic [8:0] q [$];
        exp_bits.delete();
        add_frame(0, d);
        @(posedge clk_in);
        #1;
        din[0] = d;
        vin[0] = 1'b1;
        @(posedge clk_in);
        #1;
        vin[0] = 1'b0;
        repeat (LAT - 1) @(posedge clk_in);
        for (int c = 0; c <= 45; c++) @(negedge clk_in);
        checks++;
        if (tx[0] !== exp_bits[4]) begin
            failures++;
            $display("FAIL mid_frame_bit tx=%b required %b", tx[0], exp_bits[4]);
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset tx=%b busy=%b required tx=1 busy=0", tx[0], busy[0]);
        end
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        q.push_back(9'($urandom_range(0, 255)));
        run_stream(0, q, "post_reset");
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo;
        logic [8:0] q [$];
        int exp_lvl [5] = '{1, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) q.push_back(9'($urandom_range(0, 255)));
        @(posedge clk_in);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    din[3] = q[i];
                    vin[3] = 1'b1;
                    @(negedge clk_in);
                    checks++;
                    if (rdy[3] !== 1'b1) begin
                        failures++;
                        $display("FAIL fifo_fill_ready item=%0d got %b required 1", i, rdy[3]);
                    end
                    if (i > 0) begin
                        checks++;
                        if (int'(lvl_f) != exp_lvl[i-1]) begin
                            failures++;
                            $display("FAIL fifo_level item=%0d got %0d required %0d", i, lvl_f, exp_lvl[i-1]);
                        end
                    end
                    @(posedge clk_in);
                    #1;
                end
                vin[3] = 1'b0;
                @(negedge clk_in);
                checks++;
                if (lvl_f !== 3'd4 || rdy[3] !== 1'b0) begin
                    failures++;
                    $display("FAIL fifo_full level=%0d ready=%b required 4/0", lvl_f, rdy[3]);
                end
            end
            check_stream(3, q, "fifo");
        join
        checks++;
        if (lvl_f !== 3'd0 || rdy[3] !== 1'b1) begin
            failures++;
            $display("FAIL fifo_drain level=%0d ready=%b required 0/1", lvl_f, rdy[3]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
